reaction_controller: RTL

REACTION_CONTROLLER -- requirements
Module: reaction_controller

---
 rtl/reaction_controller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/reaction_controller.sv
// Reaction-time game controller: random pre-stimulus delay, then measures ms until the react press.
// Optional BEST_TIME_EN adds a best_ms register tracking the fastest valid reaction since reset.
module reaction_controller #(
  parameter int TICKS_PER_MS = 100_000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11,
  parameter int MAX_MS       = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        react_btn,
  output logic        stimulus_led,
  output logic [13:0] reaction_ms,
  output logic        result_valid,
  output logic        false_start,
  output logic        timeout,
`ifdef BEST_TIME_EN
  output logic [13:0] best_ms,
`endif
  output logic        busy
);

  localparam int TW = $clog2(TICKS_PER_MS);

  typedef enum logic [1:0] {IDLE, WAIT, ARMED, DONE} state_t;

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [15:0]     delay_q, delay_d;
  logic [13:0]     ms_q, ms_d;
  logic            rv_q, rv_d, fs_q, fs_d, to_q, to_d;
  logic            start_prev_q, react_prev_q;
  logic            start_press, react_press, tick;
`ifdef BEST_TIME_EN
  logic [13:0]     best_q, best_d;
`endif

  assign start_press = start_btn & ~start_prev_q;
  assign react_press = react_btn & ~react_prev_q;
  assign tick = ((state_q == WAIT) || (state_q == ARMED)) &&
                (tick_cnt_q == TW'(TICKS_PER_MS - 1));
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    delay_d    = delay_q;
    ms_d       = ms_q;
    rv_d       = rv_q;
    fs_d       = fs_q;
    to_d       = to_q;
`ifdef BEST_TIME_EN
    best_d     = best_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        tick_cnt_d = '0;
        if (start_press) begin
          state_d = WAIT;
          delay_d = 16'(MIN_DELAY_MS) + 16'(lfsr_q[RAND_BITS-1:0]);
          ms_d    = '0;
          rv_d    = 1'b0;
          fs_d    = 1'b0;
          to_d    = 1'b0;
        end
      end
      WAIT: begin
        // A press beats a simultaneous tick: that press is a false start.
        if (react_press) begin
          state_d = DONE;
          fs_d    = 1'b1;
          ms_d    = '0;
        end else if (tick) begin
          if (delay_q == 16'd1) state_d = ARMED;
          else                  delay_d = delay_q - 16'd1;
        end
      end
      ARMED: begin
        if (react_press) begin
          state_d = DONE;
          rv_d    = 1'b1;
`ifdef BEST_TIME_EN
          if (ms_q < best_q) best_d = ms_q;
`endif
        end else if (tick) begin
          if (ms_q + 14'd1 == 14'(MAX_MS)) begin
            state_d = DONE;
            to_d    = 1'b1;
            ms_d    = 14'(MAX_MS);
          end else begin
            ms_d = ms_q + 14'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Every state change restarts the ms prescaler.
    if (state_d != state_q) tick_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lfsr_q       <= 16'hACE1;
      tick_cnt_q   <= '0;
      delay_q      <= '0;
      ms_q         <= '0;
      rv_q         <= 1'b0;
      fs_q         <= 1'b0;
      to_q         <= 1'b0;
      start_prev_q <= 1'b0;
      react_prev_q <= 1'b0;
`ifdef BEST_TIME_EN
      best_q       <= 14'(MAX_MS);
`endif
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      tick_cnt_q   <= tick_cnt_d;
      delay_q      <= delay_d;
      ms_q         <= ms_d;
      rv_q         <= rv_d;
      fs_q         <= fs_d;
      to_q         <= to_d;
      start_prev_q <= start_btn;
      react_prev_q <= react_btn;
`ifdef BEST_TIME_EN
      best_q       <= best_d;
`endif
    end
  end

  assign stimulus_led = (state_q == ARMED);
  assign busy         = (state_q == WAIT) || (state_q == ARMED);
  assign reaction_ms  = ms_q;
  assign result_valid = rv_q;
  assign false_start  = fs_q;
  assign timeout      = to_q;
`ifdef BEST_TIME_EN
  assign best_ms      = best_q;
`endif

endmodule
